// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
// high_cycles works at 32 bits so that N+1 cannot overflow for N = 2^CNT_W-1.
package clk_div_pkg;
   localparam int unsigned CNT_W_DEFAULT = 8;
   localparam int unsigned MIN_DIV       = 2;

   function automatic logic [31:0] high_cycles(input logic [31:0] n);
      return (n + 32'd1) >> 1;
   endfunction
endpackage

// File: rtl/clk_div_ratio_reg.sv
// Double-buffered divide ratio: shadow register, load validation and apply on wrap.
module clk_div_ratio_reg
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEFAULT,
   parameter int unsigned RESET_DIV = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_value,
   input  logic             i_wrap,
   output logic [CNT_W-1:0] o_div_active,
   output logic             o_pending,
   output logic             o_load_err
);

   logic [CNT_W-1:0] r_shadow;
   logic [CNT_W-1:0] r_active;
   logic             r_pending;
   logic             r_load_err;
   logic             w_valid;

   assign w_valid = (i_value >= CNT_W'(MIN_DIV));

   // A load on the apply edge re-arms pending, so it lands at the following wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow   <= CNT_W'(RESET_DIV);
         r_active   <= CNT_W'(RESET_DIV);
         r_pending  <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         if (i_wrap && r_pending) begin
            r_active  <= r_shadow;
            r_pending <= 1'b0;
         end
         if (i_load) begin
            if (w_valid) begin
               r_shadow   <= i_value;
               r_pending  <= 1'b1;
               r_load_err <= 1'b0;
            end else begin
               r_load_err <= 1'b1;
            end
         end
      end
   end

   assign o_div_active = r_active;
   assign o_pending    = r_pending;
   assign o_load_err   = r_load_err;

endmodule

// File: rtl/clock_divider_programmable.sv
// Runtime-programmable integer clock divider with near-50% duty and period-start tick.
// Ratio changes are applied only on the wrap edge, so clk_out never glitches.
module clock_divider_programmable
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W     = CNT_W_DEFAULT,
   parameter int unsigned RESET_DIV = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             div_load,
   input  logic [CNT_W-1:0] div_value,
   output logic             clk_out,
   output logic             tick,
   output logic [CNT_W-1:0] div_active,
   output logic             pending,
   output logic             load_err
);

   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
   logic [CNT_W-1:0] w_high;
   logic [CNT_W-1:0] w_div_active;
   logic             w_last;
   logic             w_wrap;
   logic             r_clk_out;
   logic             r_tick;

   assign w_last     = (r_cnt == (w_div_active - CNT_W'(1)));
   assign w_wrap     = enable && w_last;
   assign w_cnt_next = w_last ? '0 : r_cnt + CNT_W'(1);
   assign w_high     = CNT_W'(high_cycles(32'(w_div_active)));

   clk_div_ratio_reg #(
      .CNT_W     (CNT_W),
      .RESET_DIV (RESET_DIV)
   ) u_ratio (
      .clk          (clk),
      .reset        (reset),
      .i_load       (div_load),
      .i_value      (div_value),
      .i_wrap       (w_wrap),
      .o_div_active (w_div_active),
      .o_pending    (pending),
      .o_load_err   (load_err)
   );

   // On the apply edge cnt_next is 0 and 0 < H for any N, so the old N/H give the same result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= CNT_W'(RESET_DIV - 1);
         r_clk_out <= 1'b0;
         r_tick    <= 1'b0;
      end else if (enable) begin
         r_cnt     <= w_cnt_next;
         r_clk_out <= (w_cnt_next < w_high);
         r_tick    <= (w_cnt_next == '0);
      end else begin
         r_tick    <= 1'b0;
      end
   end

   assign clk_out    = r_clk_out;
   assign tick       = r_tick;
   assign div_active = w_div_active;

endmodule

// File: doc/clock_divider_programmable.md
# clock_divider_programmable

Runtime-programmable integer clock divider generalising the fixed power-of-two count divider. It divides `clk` by any ratio N in [2, 2^CNT_W-1] and produces a registered divided clock with near-50% duty plus a one-cycle period-start strobe. Ratio changes are double-buffered and take effect only on a period boundary, so the output never glitches. It sits between the system clock and slow peripherals, such as UART baud and sensor sampling, that need an arbitrary divided rate or enable.

## Interface
Parameters:
- `CNT_W`, default 8: counter and ratio width.
- `RESET_DIV`, default 2: ratio in effect after reset. Must be >= 2 and <= 2^CNT_W-1.

Ports:
- `clk`  in  1: system clock, rising-edge.
- `reset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: count enable. When low, the divider freezes.
- `div_load`  in  1: one-cycle strobe that requests a new ratio.
- `div_value`  in  CNT_W: requested ratio, sampled when `div_load`=1.
- `clk_out`  out  1: registered divided clock.
- `tick`  out  1: one-cycle pulse in the first `clk` cycle of each `clk_out` period.
- `div_active`  out  CNT_W: ratio currently in effect.
- `pending`  out  1: a new ratio is buffered and not yet applied.
- `load_err`  out  1: sticky flag meaning the last load was rejected.

## Operation
- Internal counter `cnt` (CNT_W bits) runs 0..N-1, where N = `div_active`. H = (N+1)>>1 is the number of high cycles per period.
- On each `clk` edge with `enable`=1:
  - `cnt_next` = 0 if `cnt`==N-1, otherwise `cnt`+1.
  - `clk_out` <= (`cnt_next` < H).
  - `tick` <= (`cnt_next`==0).
- Duty cycle:
  - Even N: exactly 50%.
  - Odd N: high for (N+1)/2 cycles, low for (N-1)/2 cycles.
- Load handling:
  - `div_load`=1 with `div_value` >= 2: shadow <= `div_value`, `pending` <= 1, `load_err` <= 0.
  - `div_load`=1 with `div_value` < 2: rejected. `load_err` <= 1, and shadow and `pending` are unchanged.
  - A second valid load while `pending`=1 overwrites the shadow. The last load wins.
- Apply:
  - On an enabled edge where `cnt`==N-1 and `pending`=1 (with `pending` registered before this edge): `div_active` <= shadow and `pending` <= 0.
  - `cnt_next`, `clk_out` and `tick` for that edge are computed with the new N and H.
  - A load that coincides with a wrap edge is applied at the following wrap.
- `enable`=0:
  - `cnt`, `clk_out` and `div_active` hold their values. `tick` <= 0.
  - Loads are still accepted into the shadow. They are applied only at an enabled wrap.
- Reset (asynchronous, at any time, including mid-period):
  - `cnt` = RESET_DIV-1, `clk_out` = 0, `tick` = 0.
  - `div_active` = RESET_DIV, `pending` = 0, `load_err` = 0, shadow = RESET_DIV.

## Timing
- All outputs are registered. There is no combinational path from any input to any output.
- First enabled edge after reset release: `cnt`=0, `clk_out`=1, `tick`=1. The first period therefore starts immediately.
- Load latency: `pending` rises 1 edge after `div_load`. The new ratio takes effect at most N_old enabled edges later.
- `clk_out` and `tick` change only on `clk` rising edges. `tick` coincides with the rising transition of `clk_out`.
- Maximum ratio 2^CNT_W-1: `cnt` never overflows, because its maximum value is 2^CNT_W-2.

## Structure
- Shared package `clk_div_pkg`:
  - `MIN_DIV` = 2.
  - Function `high_cycles(N)`, returning (N+1)>>1.
  - Default `CNT_W` localparam.
- One sub-module, `clk_div_ratio_reg`: holds the shadow register, `pending`, `load_err`, load validation and the apply handshake. It takes the wrap indication as an input.
- The top level holds the counter, `clk_out` and `tick`.

## Test plan
- Reset release, `enable`=1, RESET_DIV=2 -> `clk_out` toggles every edge and `tick` appears on every 2nd edge starting at the 1st edge.
- Load 5 mid-period at N=2 -> `pending`=1 the next cycle. After the current wrap, `div_active`=5 and `clk_out` shows a repeating pattern of 3 high, 2 low, with `tick` every 5 edges and no short pulse.
- Load 1, then load 0 -> `load_err`=1 and `div_active` is unchanged. A subsequent load of 4 clears `load_err` and applies period 4 at 50% duty.
- Load 6 on the exact wrap edge at N=3 -> one more N=3 period, then N=6. Load 7 then 9 back to back -> only 9 is applied.
- `enable` dropped for 10 cycles mid-high-phase at N=8 -> `clk_out` holds 1 and `tick`=0. The count resumes where it stopped. A load made while disabled is applied at the first enabled wrap.
- Assert reset mid-period with `pending`=1 -> all outputs take their reset values immediately, without waiting for a clock edge, and the pending ratio is discarded.
